// File: rtl/johnson_phase_ctrl.sv
// Johnson (twisted-ring) phase sequencer: bursts of N steps, free-run, hold,
// abort and direct loading of a legal phase code.
module johnson_phase_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] steps,
    input  logic             cont,
    input  logic             dir,
    input  logic             hold,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] phase,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remain,
    output logic             err
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] phase_reg, phase_next;
    logic [CNT_W-1:0] remain_reg, remain_next;
    logic             dir_reg, dir_next;
    logic             cont_reg, cont_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    // A legal code is a run of ones anchored at the LSB or at the MSB.
    logic [WIDTH:0] lsb_hit, msb_hit;
    logic           load_legal;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_legal
            assign lsb_hit[gi] = (load_val == (ONES >> gi));
            assign msb_hit[gi] = (load_val == (ONES << gi));
        end
    endgenerate

    assign load_legal = (|lsb_hit) | (|msb_hit);

    logic [WIDTH-1:0] step_right, step_left;
    assign step_right = {~phase_reg[0], phase_reg[WIDTH-1:1]};
    assign step_left  = {phase_reg[WIDTH-2:0], ~phase_reg[WIDTH-1]};

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        remain_next = remain_reg;
        dir_next    = dir_reg;
        cont_next   = cont_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load) begin
                    if (load_legal) begin
                        phase_next = load_val;
                    end else begin
                        phase_next = '0;
                        err_next   = 1'b1;
                    end
                end else if (start) begin
                    if (!cont && steps == '0) begin
                        done_next = 1'b1;
                    end else begin
                        dir_next    = dir;
                        cont_next   = cont;
                        remain_next = cont ? '0 : steps;
                        state_next  = RUN;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next  = IDLE;
                    remain_next = '0;
                end else if (!hold) begin
                    phase_next = dir_reg ? step_left : step_right;
                    if (!cont_reg) begin
                        // remain is at least 1 here, so the decrement cannot wrap.
                        remain_next = remain_reg - ONE;
                        if (remain_reg == ONE) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            phase_reg  <= '0;
            remain_reg <= '0;
            dir_reg    <= 1'b0;
            cont_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            remain_reg <= remain_next;
            dir_reg    <= dir_next;
            cont_reg   <= cont_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign phase  = phase_reg;
    assign busy   = (state_reg == RUN);
    assign done   = done_reg;
    assign remain = remain_reg;
    assign err    = err_reg;

endmodule

// File: doc/johnson_phase_ctrl.md
Name: johnson_phase_ctrl

Overview:
- Sequencer that owns a WIDTH-bit Johnson (twisted-ring) phase register and advances it under command control.
- Supported modes: bursts of N steps, free-running, hold/pause, abort, and direct loading of a phase code.
- Sits between a control FSM or register bank and downstream logic that consumes one-hot-decodable multi-phase enables.

Parameters:
WIDTH, 4, Johnson ring width; 2*WIDTH distinct legal codes
CNT_W, 8, width of step count and remaining counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
steps  input  CNT_W  number of advances for a burst; sampled with start
cont  input  1  1 = free-run until stop (steps ignored); sampled with start
dir  input  1  0 = shift right, 1 = shift left; sampled with start
hold  input  1  freeze advance while in RUN
stop  input  1  abort RUN
load  input  1  load phase from load_val; IDLE only
load_val  input  WIDTH  phase code to load
phase  output  WIDTH  current Johnson code
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on burst completion
remain  output  CNT_W  advances left in current burst (0 in cont mode and in IDLE)
err  output  1  one-cycle pulse on illegal load_val

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk. All outputs and state clear to 0 at the next edge, including when reset is asserted mid-burst. State returns to IDLE.
- FSM states: IDLE, RUN.
- Right step (dir=0): phase <= {~phase[0], phase[WIDTH-1:1]}.
- Left step (dir=1): phase <= {phase[WIDTH-2:0], ~phase[WIDTH-1]}.
- Legal codes: all ones in a contiguous run anchored at the MSB or at the LSB, including all-0 and all-1.
- IDLE priority is load > start. All other inputs are ignored in IDLE.
  - load=1 with a legal load_val: phase <= load_val at the next edge.
  - load=1 with an illegal load_val: phase <= 0 and err=1 for one cycle. A start asserted in the same cycle is dropped.
  - start=1, cont=0, steps=0: stay in IDLE; done=1 for the next cycle; phase unchanged.
  - start=1 otherwise: latch dir and cont; remain <= steps (or 0 if cont); go to RUN with busy=1 from the next cycle. Phase does not advance on the start edge.
- RUN, evaluated each edge, priority stop > hold > advance:
  - stop=1: go to IDLE; no advance; remain <= 0; busy <= 0; no done.
  - hold=1: no advance; remain unchanged; stay in RUN.
  - Otherwise: phase steps once in the latched dir.
    - If cont=0: remain decrements. When remain was 1, go to IDLE; busy <= 0 and done <= 1 at the same edge, so done is coincident with the final phase.
    - If cont=1: remain stays 0; run continues indefinitely, with the phase wrapping every 2*WIDTH advances.
- Any burst of N with no holds: busy is high for exactly N cycles; done pulses in the cycle after busy's last cycle. Each hold cycle extends busy by one cycle.
- start and load are ignored while busy. Changes to dir, cont and steps mid-run have no effect.
- phase holds its value in IDLE. Every burst continues from the current phase.
- done and err are single-cycle pulses, never asserted together.
- remain counts down; it never wraps or underflows.

Test Plan:
- Reset; start with steps=3, dir=0 from 0000 -> phase 1000, 1100, 1110; busy high 3 cycles; done=1 for one cycle with phase=1110, remain=0.
- start with steps=8, dir=1 from 0000 -> 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 (full wrap); done after the 8th advance; remain counts 8 down to 0.
- Burst steps=4, dir=0, with hold=1 for 2 cycles after the 2nd advance -> phase frozen at 1100 during hold; busy high 6 cycles total; final phase 1111; single done.
- cont=1, dir=0, stop asserted after 5 advances -> phase 0111; busy drops the next cycle; done never asserted; remain stays 0 throughout.
- IDLE load with load_val=0011 -> phase=0011, err=0. load with load_val=0101 -> phase=0000, err=1 for one cycle. load+start in the same cycle -> only the load takes effect, busy stays 0.
- Boundary checks:
  - start with steps=0, cont=0 -> busy stays 0; done pulses once; phase unchanged.
  - start pulsed while busy -> ignored.
  - rst_n=0 mid-burst -> phase, busy, remain, done and err all 0 at the next edge; state is IDLE.
